// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared definitions for the bit-serial subtractor. Holds the
//               FSM state encodings used by serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  localparam int          C_STATE_W = 2;

  localparam logic [1:0]  C_IDLE    = 2'd0;
  localparam logic [1:0]  C_SHIFT   = 2'd1;
  localparam logic [1:0]  C_DONE    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fullsubstractor.sv
`default_nettype none
// ============================================================================
// Module      : fullsubstractor
// Description : Combinational 1-bit full subtractor: d = a - b - bin.
//   i_a    : minuend bit
//   i_b    : subtrahend bit
//   i_bin  : borrow in
//   o_d    : difference bit
//   o_bout : borrow out
// Revision    : 1.0 - initial release
// ============================================================================
module fullsubstractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_ab_eq;

  assign w_ab_eq = ~(i_a ^ i_b);
  assign o_d     = i_a ^ i_b ^ i_bin;
  // Borrow when a=0,b=1, or when the operand bits cancel and a borrow arrives.
  assign o_bout  = (~i_a & i_b) | (w_ab_eq & i_bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor, diff = a - b mod 2^WIDTH,
//               LSB first, one bit per clock. A result takes WIDTH+2 cycles
//               from accepted start to the next possible start.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : request, accepted only in IDLE
//   a, b       : operands, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse, diff/borrow_out valid
//   diff       : result, held in IDLE until the next accepted start
//   borrow_out : final borrow, high when a < b
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            C_CW   = $clog2(WIDTH + 1);
  // Count value seen on the WIDTH-th shift edge; the counter itself ends at
  // WIDTH so it never wraps inside an operation.
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

  logic [C_STATE_W-1:0] r_state;
  logic [WIDTH-1:0]     r_a_sh;
  logic [WIDTH-1:0]     r_b_sh;
  logic [WIDTH-1:0]     r_diff;
  logic                 r_borrow;
  logic [C_CW-1:0]      r_cnt;

  logic                 w_d;
  logic                 w_bout;

  fullsubstractor u_cell (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= C_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= C_SHIFT;
          end
        end
        C_SHIFT: begin
          // Difference bits enter at the MSB so that after WIDTH shifts the
          // first (LSB) result bit has reached bit 0.
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_diff   <= {w_d, r_diff[WIDTH-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + C_CW'(1);
          if (r_cnt == C_LAST) begin
            r_state <= C_DONE;
          end
        end
        C_DONE: begin
          r_state <= C_IDLE;
        end
        default: begin
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state == C_SHIFT);
  assign done       = (r_state == C_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8). Expected
//               results come from plain unsigned arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int  n_vec;
  int  n_err;
  time t_done;
  time t_prev;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation. hold keeps start high throughout; inj >= 0 pulses a
  // foreign start (0x11/0x22) during that SHIFT cycle index.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input bit hold, input int inj);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] exp_d;
    logic             exp_b;
    full  = {1'b0, ta} - {1'b0, tb_};
    exp_d = full[WIDTH-1:0];
    exp_b = (ta < tb_);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    step();
    if (!hold) start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == inj) begin
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
      end else if (inj >= 0 && i == inj + 1) begin
        start = 1'b0;
      end
      check("busy_shift", {31'd0, busy}, 32'd1);
      check("done_early", {31'd0, done}, 32'd0);
      step();
    end
    t_done = $time;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("diff", {24'd0, diff}, {24'd0, exp_d});
    check("borrow", {31'd0, borrow_out}, {31'd0, exp_b});
    step();
    check("done_width", {31'd0, done}, 32'd0);
    check("diff_hold", {24'd0, diff}, {24'd0, exp_d});
    check("borrow_hold", {31'd0, borrow_out}, {31'd0, exp_b});
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    t_done = 0;
    t_prev = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;

    // Reset state
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow_out}, 32'd0);
    #19 rst_n = 1'b1;
    step();

    // Directed cases
    run_op(8'h5A, 8'h3C, 1'b0, -1);
    run_op(8'h00, 8'h01, 1'b0, -1);
    run_op(8'hFF, 8'hFF, 1'b0, -1);
    run_op(8'hFF, 8'h00, 1'b0, -1);

    // Start pulsed in the third SHIFT cycle must be ignored
    run_op(8'h80, 8'h01, 1'b0, 2);
    step();
    check("no_restart_busy", {31'd0, busy}, 32'd0);
    check("no_second_done", {31'd0, done}, 32'd0);

    // Reset in the fourth SHIFT cycle, asserted between clock edges
    start = 1'b1;
    a     = 8'h00;
    b     = 8'h01;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_borrow", {31'd0, borrow_out}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 4; i++) begin
      step();
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_op(8'hC3, 8'h3C, 1'b0, -1);

    // start held high: three back-to-back operations, WIDTH+2 cycles apart
    run_op(8'h10, 8'h20, 1'b1, -1);
    t_prev = t_done;
    run_op(8'h9C, 8'h47, 1'b1, -1);
    check("done_spacing1", 32'(t_done - t_prev), 32'd100);
    t_prev = t_done;
    run_op(8'h33, 8'h33, 1'b1, -1);
    check("done_spacing2", 32'(t_done - t_prev), 32'd100);
    start = 1'b0;
    step();

    // Random operand pairs, with periodic equal operands
    for (int n = 0; n < 1000; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (n % 50 == 0) rb = ra;
      run_op(ra, rb, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
